ctrl_fsm_mc: RTL and testbench

Multi-cycle control unit that replaces the single-cycle opcode decoder in the CPU core. It accepts one opcode per instruction over a valid/ready handshake and registers the decoded datapath controls. It then sequences the instruction through execute, optional multiply wait, optional memory wait, and write-back. It sits between fetch (upstream) and the register file, ALU and data-memory port (downstream).

---
 rtl/ctrl_pkg.sv | 57 +++++
 rtl/ctrl_decode_rom.sv | 106 ++++++++++
 rtl/ctrl_fsm_mc.sv | 146 ++++++++++++++
 tb/tb_ctrl_fsm_mc.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes,
// FSM state encoding and the decoded datapath control bundle.
package ctrl_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_MUL  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_LDB  = 6'd10;
    localparam logic [5:0] OP_LDW  = 6'd11;
    localparam logic [5:0] OP_STB  = 6'd12;
    localparam logic [5:0] OP_STW  = 6'd13;
    localparam logic [5:0] OP_MOV  = 6'd14;
    localparam logic [5:0] OP_BEQ  = 6'd20;
    localparam logic [5:0] OP_JUMP = 6'd21;
    localparam logic [5:0] OP_TLBW = 6'd30;
    localparam logic [5:0] OP_IRET = 6'd31;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_PASS = 4'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_MUL,
        CL_MEM,
        CL_BR,
        CL_SYS,
        CL_ILL
    } op_class_e;

    typedef struct packed {
        logic       reg_dest;
        logic       alu_src;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       mem_byte;
        logic [3:0] alu_ctrl;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       tlb_write;
        logic       iret;
    } dec_fields_t;

endpackage

// File: rtl/ctrl_decode_rom.sv
// Combinational opcode decoder: opcode -> control fields and sequencing class.
// MUL decodes only when CTRL_MUL_EN is defined; otherwise opcode 2 is illegal.
module ctrl_decode_rom
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output dec_fields_t     fields,
    output op_class_e       op_class
);

    logic is_alu;
    logic is_addi;
    logic is_load;
    logic is_store;
    logic is_mov;
    logic is_beq;
    logic is_jump;
    logic is_tlbw;
    logic is_iret;

    assign is_alu = (op == OP_W'(OP_ADD)) || (op == OP_W'(OP_SUB))
                 || (op == OP_W'(OP_AND)) || (op == OP_W'(OP_OR));
    assign is_addi  = (op == OP_W'(OP_ADDI));
    assign is_load  = (op == OP_W'(OP_LDB)) || (op == OP_W'(OP_LDW));
    assign is_store = (op == OP_W'(OP_STB)) || (op == OP_W'(OP_STW));
    assign is_mov   = (op == OP_W'(OP_MOV));
    assign is_beq   = (op == OP_W'(OP_BEQ));
    assign is_jump  = (op == OP_W'(OP_JUMP));
    assign is_tlbw  = (op == OP_W'(OP_TLBW));
    assign is_iret  = (op == OP_W'(OP_IRET));

`ifdef CTRL_MUL_EN
    logic is_mul;
    assign is_mul = (op == OP_W'(OP_MUL));
`endif

    always_comb begin
        fields   = '0;
        op_class = CL_ILL;
        unique case (1'b1)
            is_alu: begin
                op_class           = CL_ALU;
                fields.reg_dest    = 1'b1;
                fields.alu_ctrl    = 4'(op);
                fields.reg_write   = 1'b1;
            end
`ifdef CTRL_MUL_EN
            is_mul: begin
                op_class           = CL_MUL;
                fields.reg_dest    = 1'b1;
                fields.alu_ctrl    = ALU_MUL;
                fields.reg_write   = 1'b1;
            end
`endif
            is_addi: begin
                op_class           = CL_ALU;
                fields.alu_src     = 1'b1;
                fields.alu_ctrl    = ALU_ADD;
                fields.reg_write   = 1'b1;
            end
            is_load: begin
                op_class           = CL_MEM;
                fields.alu_src     = 1'b1;
                fields.mem_to_reg  = 1'b1;
                fields.mem_byte    = (op == OP_W'(OP_LDB));
                fields.reg_write   = 1'b1;
                fields.mem_read    = 1'b1;
            end
            is_store: begin
                op_class           = CL_MEM;
                fields.alu_src     = 1'b1;
                fields.mem_byte    = (op == OP_W'(OP_STB));
                fields.mem_write   = 1'b1;
            end
            is_mov: begin
                op_class           = CL_ALU;
                fields.reg_dest    = 1'b1;
                fields.alu_ctrl    = ALU_PASS;
                fields.reg_write   = 1'b1;
            end
            is_beq: begin
                op_class           = CL_BR;
                fields.branch      = 1'b1;
                fields.alu_ctrl    = ALU_SUB;
            end
            is_jump: begin
                op_class           = CL_BR;
                fields.jump        = 1'b1;
            end
            is_tlbw: begin
                op_class           = CL_SYS;
                fields.tlb_write   = 1'b1;
            end
            is_iret: begin
                op_class           = CL_SYS;
                fields.iret        = 1'b1;
            end
            default: begin
                op_class           = CL_ILL;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle control FSM: IDLE -> EXEC -> [MEM] -> WB, with decoded fields
// registered at accept. CTRL_MUL_EN enables the multi-cycle MUL path.
module ctrl_fsm_mc
    import ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALU_CTRL_W  = 4,
    parameter int MUL_CYCLES  = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [OP_W-1:0]       op,
    output logic                  op_ready,
    input  logic                  mem_ack,
    output logic                  reg_dest,
    output logic                  alu_src,
    output logic                  mem_to_reg,
    output logic                  branch,
    output logic                  jump,
    output logic                  mem_byte,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  tlb_write,
    output logic                  iret,
    output logic                  done,
    output logic                  illegal_op,
    output logic                  mem_err,
    output logic                  busy
);

`ifdef CTRL_MUL_EN
    localparam int CNT_MAX = (MUL_CYCLES > MEM_TIMEOUT) ? MUL_CYCLES : MEM_TIMEOUT;
`else
    // MUL_CYCLES has no effect in this build
    localparam int CNT_MAX = MEM_TIMEOUT + 0 * MUL_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    dec_fields_t      rom_fields;
    dec_fields_t      fields_d;
    dec_fields_t      fields_q;
    op_class_e        rom_class;
    op_class_e        class_d;
    op_class_e        class_q;
    logic [1:0]       state_d;
    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             mem_last;

    ctrl_decode_rom #(
        .OP_W(OP_W)
    ) u_rom (
        .op      (op),
        .fields  (rom_fields),
        .op_class(rom_class)
    );

    assign op_ready = (state_q == S_IDLE) && !rst;
    assign accept   = op_valid && op_ready;
    assign mem_last = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fields_d = fields_q;
        class_d  = class_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_EXEC;
                    cnt_d    = '0;
                    fields_d = rom_fields;
                    class_d  = rom_class;
                end
            end
            S_EXEC: begin
                cnt_d = '0;
                unique case (class_q)
                    CL_ILL:  state_d = S_IDLE;
                    CL_MEM:  state_d = S_MEM;
`ifdef CTRL_MUL_EN
                    CL_MUL: begin
                        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                            state_d = S_WB;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
`endif
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                // an ack in the final timeout cycle still completes the access
                if (mem_ack) begin
                    state_d = S_WB;
                end else if (mem_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fields_q <= '0;
            class_q  <= CL_ALU;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fields_q <= fields_d;
            class_q  <= class_d;
        end
    end

    assign reg_dest   = fields_q.reg_dest;
    assign alu_src    = fields_q.alu_src;
    assign mem_to_reg = fields_q.mem_to_reg;
    assign branch     = fields_q.branch;
    assign jump       = fields_q.jump;
    assign mem_byte   = fields_q.mem_byte;
    assign alu_ctrl   = ALU_CTRL_W'(fields_q.alu_ctrl);

    assign busy       = (state_q != S_IDLE);
    assign mem_read   = (state_q == S_MEM) && fields_q.mem_read;
    assign mem_write  = (state_q == S_MEM) && fields_q.mem_write;
    assign done       = (state_q == S_WB);
    assign reg_write  = done && fields_q.reg_write;
    assign tlb_write  = done && fields_q.tlb_write;
    assign iret       = done && fields_q.iret;
    assign illegal_op = (state_q == S_EXEC) && (class_q == CL_ILL);
    assign mem_err    = (state_q == S_MEM) && mem_last && !mem_ack;

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Self-checking bench for ctrl_fsm_mc: directed scenarios plus randomized
// instruction streams checked against a cycle-count reference model.
module tb_ctrl_fsm_mc;

    localparam int MUL_C = 3;
    localparam int TMO   = 4;
`ifdef CTRL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam int B_BUSY   = 19;
    localparam int B_READY  = 18;
    localparam int B_DONE   = 17;
    localparam int B_RW     = 16;
    localparam int B_MRD    = 13;
    localparam int B_MWR    = 12;
    localparam int B_ILL    = 11;
    localparam int B_MERR   = 10;
    localparam int B_M2R    = 7;
    localparam int B_BRANCH = 6;
    localparam int B_MBYTE  = 4;

    typedef struct packed {
        logic       busy;
        logic       op_ready;
        logic       done;
        logic       reg_write;
        logic       tlb_write;
        logic       iret;
        logic       mem_read;
        logic       mem_write;
        logic       illegal_op;
        logic       mem_err;
        logic       reg_dest;
        logic       alu_src;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       mem_byte;
        logic [3:0] alu_ctrl;
    } snap_t;

    typedef struct packed {
        logic       legal;
        logic       wr;
        logic       ld;
        logic       st;
        logic       tlb;
        logic       iret;
        logic       mul;
        logic [9:0] stat;
    } ref_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       op_valid = 1'b0;
    logic [5:0] op = '0;
    logic       mem_ack = 1'b0;
    logic       op_ready;
    logic       reg_dest;
    logic       alu_src;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       mem_byte;
    logic [3:0] alu_ctrl;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       tlb_write;
    logic       iret;
    logic       done;
    logic       illegal_op;
    logic       mem_err;
    logic       busy;

    int    n_chk  = 0;
    int    n_fail = 0;
    snap_t obs[0:7];

    ctrl_fsm_mc #(
        .OP_W       (6),
        .ALU_CTRL_W (4),
        .MUL_CYCLES (MUL_C),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op        (op),
        .op_ready  (op_ready),
        .mem_ack   (mem_ack),
        .reg_dest  (reg_dest),
        .alu_src   (alu_src),
        .mem_to_reg(mem_to_reg),
        .branch    (branch),
        .jump      (jump),
        .mem_byte  (mem_byte),
        .alu_ctrl  (alu_ctrl),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .tlb_write (tlb_write),
        .iret      (iret),
        .done      (done),
        .illegal_op(illegal_op),
        .mem_err   (mem_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic snap_t snap();
        snap_t s;
        s.busy       = busy;
        s.op_ready   = op_ready;
        s.done       = done;
        s.reg_write  = reg_write;
        s.tlb_write  = tlb_write;
        s.iret       = iret;
        s.mem_read   = mem_read;
        s.mem_write  = mem_write;
        s.illegal_op = illegal_op;
        s.mem_err    = mem_err;
        s.reg_dest   = reg_dest;
        s.alu_src    = alu_src;
        s.mem_to_reg = mem_to_reg;
        s.branch     = branch;
        s.jump       = jump;
        s.mem_byte   = mem_byte;
        s.alu_ctrl   = alu_ctrl;
        return s;
    endfunction

    // One signal across cycles 0..7 of the last capture, bit c = cycle c
    function automatic logic [7:0] col(input int b);
        logic [7:0] v;
        for (int c = 0; c < 8; c++) v[c] = obs[c][b];
        return v;
    endfunction

    // Offer o1 in cycle 0, ack in MEM cycle k (0 = never), optional o2 in cycle t2
    task automatic capture(input logic [5:0] o1, input int k,
                           input logic [5:0] o2, input int t2);
        @(negedge clk);
        op_valid = 1'b1;
        op       = o1;
        mem_ack  = 1'b0;
        #1 obs[0] = snap();
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            op_valid = (t2 > 0) && (c == t2);
            if ((t2 > 0) && (c == t2)) op = o2;
            mem_ack = (k > 0) && (c == k + 1);
            #1 obs[c] = snap();
        end
        op_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    function automatic ref_t ref_dec(input int o);
        ref_t r;
        r = '0;
        r.legal = 1'b1;
        case (o)
            0, 1, 3, 4: begin r.wr = 1; r.stat = {6'b100000, 4'(o)}; end
            2: begin
                r.legal = MUL_EN;
                r.wr    = MUL_EN;
                r.mul   = MUL_EN;
                r.stat  = MUL_EN ? {6'b100000, 4'd2} : 10'd0;
            end
            5:  begin r.wr = 1; r.stat = {6'b010000, 4'd0}; end
            10: begin r.wr = 1; r.ld = 1; r.stat = {6'b011001, 4'd0}; end
            11: begin r.wr = 1; r.ld = 1; r.stat = {6'b011000, 4'd0}; end
            12: begin r.st = 1; r.stat = {6'b010001, 4'd0}; end
            13: begin r.st = 1; r.stat = {6'b010000, 4'd0}; end
            14: begin r.wr = 1; r.stat = {6'b100000, 4'd5}; end
            20: r.stat = {6'b000100, 4'd1};
            21: r.stat = {6'b000010, 4'd0};
            30: r.tlb = 1;
            31: r.iret = 1;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        logic [4:0] dn;
        #1 rst = 1'b1;
        #3;
        n_chk++; if (snap() !== '0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", snap()); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_chk++; if ({op_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL reset_release ready/busy got %b want 10", {op_ready, busy}); end
        // abort a load while it waits in MEM
        @(negedge clk);
        op_valid = 1'b1;
        op       = 6'd11;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        #1;
        n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL reset_pre_mem_read got %b want 1", mem_read); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (snap() !== '0) begin n_fail++; $display("FAIL reset_mid_load got %h want 0", snap()); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_ack = (c == 1);
            #1 dn[c] = done;
            if (c == 0) begin
                n_chk++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", op_ready); end
            end
        end
        mem_ack = 1'b0;
        n_chk++; if (dn !== 5'b0) begin n_fail++; $display("FAIL reset_no_done got %b want 00000", dn); end
    endtask

    task automatic test_add();
        capture(6'd0, 0, 6'd0, 0);
        n_chk++; if (col(B_READY) !== 8'b11111001) begin n_fail++; $display("FAIL add_ready got %b want 11111001", col(B_READY)); end
        n_chk++; if ({obs[1].reg_dest, obs[1].alu_ctrl} !== 5'b10000) begin n_fail++; $display("FAIL add_fields got %b want 10000", {obs[1].reg_dest, obs[1].alu_ctrl}); end
        n_chk++; if (col(B_DONE) !== 8'b00000100) begin n_fail++; $display("FAIL add_done got %b want 00000100", col(B_DONE)); end
        n_chk++; if (col(B_RW) !== 8'b00000100) begin n_fail++; $display("FAIL add_reg_write got %b want 00000100", col(B_RW)); end
    endtask

    task automatic test_back_to_back();
        capture(6'd0, 0, 6'd1, 3);
        n_chk++; if (col(B_DONE) !== 8'b00100100) begin n_fail++; $display("FAIL b2b_done got %b want 00100100", col(B_DONE)); end
        n_chk++; if (col(B_READY) !== 8'b11001001) begin n_fail++; $display("FAIL b2b_ready got %b want 11001001", col(B_READY)); end
        n_chk++; if (obs[4].alu_ctrl !== 4'd1) begin n_fail++; $display("FAIL b2b_sub_alu got %0d want 1", obs[4].alu_ctrl); end
    endtask

    task automatic test_load_store();
        capture(6'd11, 3, 6'd0, 0);
        n_chk++; if (col(B_MRD) !== 8'b00011100) begin n_fail++; $display("FAIL ldw_mem_read got %b want 00011100", col(B_MRD)); end
        n_chk++; if (col(B_DONE) !== 8'b00100000) begin n_fail++; $display("FAIL ldw_done got %b want 00100000", col(B_DONE)); end
        n_chk++; if (col(B_RW) !== 8'b00100000) begin n_fail++; $display("FAIL ldw_reg_write got %b want 00100000", col(B_RW)); end
        n_chk++; if (col(B_M2R) !== 8'b11111110) begin n_fail++; $display("FAIL ldw_mem_to_reg got %b want 11111110", col(B_M2R)); end
        n_chk++; if (col(B_READY) !== 8'b11000001) begin n_fail++; $display("FAIL ldw_ready got %b want 11000001", col(B_READY)); end
        capture(6'd12, 3, 6'd0, 0);
        n_chk++; if (col(B_MBYTE) !== 8'b11111110) begin n_fail++; $display("FAIL stb_mem_byte got %b want 11111110", col(B_MBYTE)); end
        n_chk++; if (col(B_MWR) !== 8'b00011100) begin n_fail++; $display("FAIL stb_mem_write got %b want 00011100", col(B_MWR)); end
        n_chk++; if (col(B_MRD) !== 8'b00000000) begin n_fail++; $display("FAIL stb_mem_read got %b want 00000000", col(B_MRD)); end
        n_chk++; if (col(B_DONE) !== 8'b00100000) begin n_fail++; $display("FAIL stb_done got %b want 00100000", col(B_DONE)); end
        n_chk++; if (col(B_RW) !== 8'b00000000) begin n_fail++; $display("FAIL stb_reg_write got %b want 00000000", col(B_RW)); end
    endtask

    task automatic test_timeout();
        capture(6'd13, 0, 6'd0, 0);
        n_chk++; if (col(B_MERR) !== 8'b00100000) begin n_fail++; $display("FAIL tmo_mem_err got %b want 00100000", col(B_MERR)); end
        n_chk++; if (col(B_DONE) !== 8'b00000000) begin n_fail++; $display("FAIL tmo_done got %b want 00000000", col(B_DONE)); end
        n_chk++; if (col(B_BUSY) !== 8'b00111110) begin n_fail++; $display("FAIL tmo_busy got %b want 00111110", col(B_BUSY)); end
        n_chk++; if (col(B_MWR) !== 8'b00111100) begin n_fail++; $display("FAIL tmo_mem_write got %b want 00111100", col(B_MWR)); end
        // ack arriving in the last allowed MEM cycle wins over the timeout
        capture(6'd13, TMO, 6'd0, 0);
        n_chk++; if (col(B_MERR) !== 8'b00000000) begin n_fail++; $display("FAIL ackwin_mem_err got %b want 00000000", col(B_MERR)); end
        n_chk++; if (col(B_DONE) !== 8'b01000000) begin n_fail++; $display("FAIL ackwin_done got %b want 01000000", col(B_DONE)); end
    endtask

    task automatic test_mul();
        capture(6'd2, 0, 6'd0, 0);
`ifdef CTRL_MUL_EN
        n_chk++; if (col(B_DONE) !== 8'b00010000) begin n_fail++; $display("FAIL mul_done got %b want 00010000", col(B_DONE)); end
        n_chk++; if (col(B_BUSY) !== 8'b00011110) begin n_fail++; $display("FAIL mul_busy got %b want 00011110", col(B_BUSY)); end
        n_chk++; if (obs[1].alu_ctrl !== 4'd2) begin n_fail++; $display("FAIL mul_alu got %0d want 2", obs[1].alu_ctrl); end
`else
        n_chk++; if (col(B_ILL) !== 8'b00000010) begin n_fail++; $display("FAIL mul_illegal got %b want 00000010", col(B_ILL)); end
        n_chk++; if (col(B_DONE) !== 8'b00000000) begin n_fail++; $display("FAIL mul_done got %b want 00000000", col(B_DONE)); end
`endif
    endtask

    task automatic test_illegal_beq();
        capture(6'd7, 0, 6'd20, 2);
        n_chk++; if (col(B_ILL) !== 8'b00000010) begin n_fail++; $display("FAIL ill_pulse got %b want 00000010", col(B_ILL)); end
        n_chk++; if (col(B_READY) !== 8'b11100101) begin n_fail++; $display("FAIL ill_beq_ready got %b want 11100101", col(B_READY)); end
        n_chk++; if (col(B_DONE) !== 8'b00010000) begin n_fail++; $display("FAIL beq_done got %b want 00010000", col(B_DONE)); end
        n_chk++; if (col(B_RW) !== 8'b00000000) begin n_fail++; $display("FAIL beq_reg_write got %b want 00000000", col(B_RW)); end
        n_chk++; if (col(B_BRANCH) !== 8'b11111000) begin n_fail++; $display("FAIL beq_branch got %b want 11111000", col(B_BRANCH)); end
        n_chk++; if (obs[3].alu_ctrl !== 4'd1) begin n_fail++; $display("FAIL beq_alu got %0d want 1", obs[3].alu_ctrl); end
    endtask

    task automatic test_random();
        int         pool[15] = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 13, 14, 20, 21, 30, 31};
        logic [9:0] prev;
        ref_t       r;
        snap_t      e;
        snap_t      s;
        int         o, k, gap, endc, meml;
        bit         tmo, inmem;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        prev = '0;
        for (int it = 0; it < 150; it++) begin
            o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                            : pool[$urandom_range(0, 14)];
            k   = $urandom_range(1, TMO + 2);
            r   = ref_dec(o);
            tmo = 1'b0;
            meml = 0;
            if (!r.legal) endc = 1;
            else if (r.mul) endc = 1 + MUL_C;
            else if (r.ld || r.st) begin
                if (k <= TMO) begin endc = 2 + k; meml = 1 + k; end
                else begin tmo = 1'b1; endc = 1 + TMO; meml = endc; end
            end else endc = 2;
            gap = $urandom_range(0, 2);
            for (int g = 0; g <= gap; g++) begin
                @(negedge clk);
                op_valid = (g == gap);
                op       = (g == gap) ? 6'(o) : 6'($urandom);
                mem_ack  = 1'($urandom);
                #1 s = snap();
                e = '0;
                e.op_ready = 1'b1;
                {e.reg_dest, e.alu_src, e.mem_to_reg, e.branch, e.jump, e.mem_byte, e.alu_ctrl} = prev;
                n_chk++; if (s !== e) begin n_fail++; $display("FAIL rand_idle it=%0d op=%0d got %h want %h", it, o, s, e); end
            end
            for (int c = 1; c <= endc; c++) begin
                @(negedge clk);
                inmem    = (r.ld || r.st) && (c >= 2) && (c <= meml);
                op_valid = 1'($urandom);
                op       = 6'($urandom);
                mem_ack  = inmem ? (c == k + 1) : 1'($urandom);
                #1 s = snap();
                e = '0;
                e.busy       = 1'b1;
                e.done       = r.legal && !tmo && (c == endc);
                e.reg_write  = e.done && r.wr;
                e.tlb_write  = e.done && r.tlb;
                e.iret       = e.done && r.iret;
                e.mem_read   = inmem && r.ld;
                e.mem_write  = inmem && r.st;
                e.illegal_op = !r.legal && (c == 1);
                e.mem_err    = tmo && (c == endc);
                {e.reg_dest, e.alu_src, e.mem_to_reg, e.branch, e.jump, e.mem_byte, e.alu_ctrl} = r.stat;
                n_chk++; if (s !== e) begin n_fail++; $display("FAIL rand_busy it=%0d op=%0d k=%0d cyc=%0d got %h want %h", it, o, k, c, s, e); end
            end
            op_valid = 1'b0;
            mem_ack  = 1'b0;
            prev     = r.stat;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_load_store();
        test_timeout();
        test_mul();
        test_illegal_beq();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
